// File: rtl/avm_pkg.sv
// Shared types and helpers for the byte-wide Avalon-MM initiator and its lane steering.
package avm_pkg;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 7;
  localparam int unsigned LAT_CNT_W    = $clog2(READ_LAT_MAX + 1);
  localparam int unsigned LANES        = 4;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = LANES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte offset within a word to a strictly one-hot byteenable.
  function automatic logic [LANES-1:0] lane_decode(input logic [1:0] lane);
    logic [LANES-1:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0010;
      2'd2:    be = 4'b0100;
      default: be = 4'b1000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/avm_lane_sel.sv
// Combinational byte-lane steering: 32-to-8 read mux and one-hot byteenable decode.
module avm_lane_sel
  import avm_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] data,
  output logic [BYTE_W-1:0] lane_byte_c,
  output logic [LANES-1:0]  byteenable_c
);

  always_comb begin
    lane_byte_c = data[7:0];
    case (lane)
      2'd0:    lane_byte_c = data[7:0];
      2'd1:    lane_byte_c = data[15:8];
      2'd2:    lane_byte_c = data[23:16];
      default: lane_byte_c = data[31:24];
    endcase
  end

  assign byteenable_c = lane_decode(lane);

endmodule

// File: rtl/avm_byte_master.sv
// Avalon-MM initiator turning single-byte CPU requests into 32-bit word transactions.
module avm_byte_master
  import avm_pkg::*;
#(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [BYTE_W-1:0]   wdata,
  output logic                ack,
  output logic [BYTE_W-1:0]   rdata,
  output logic                busy,
  output logic [ADDR_W-3:0]   avm_address,
  output logic [LANES-1:0]    avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [WORD_W-1:0]   avm_writedata,
  input  logic [WORD_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic                avm_clken
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

  state_t               state, state_n;
  logic [ADDR_W-1:0]    addr_q, addr_n;
  logic                 we_q, we_n;
  logic [BYTE_W-1:0]    wdata_q, wdata_n;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_n;

  logic                 ack_n, busy_n, cs_n, write_n, read_n;
  logic [BYTE_W-1:0]    rdata_n;
  logic [LANES-1:0]     be_n;

  logic [1:0]           lane_c;
  logic [BYTE_W-1:0]    lane_byte_c;
  logic [LANES-1:0]     lane_be_c;

  // In IDLE the decode sees the incoming address so byteenable can be registered with the command.
  assign lane_c = (state == IDLE) ? addr[1:0] : addr_q[1:0];

  avm_lane_sel u_lane_sel (
    .lane         (lane_c),
    .data         (avm_readdata),
    .lane_byte_c  (lane_byte_c),
    .byteenable_c (lane_be_c)
  );

  assign avm_address   = addr_q[ADDR_W-1:2];
  assign avm_writedata = {LANES{wdata_q}};

  // State, command and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      ack            <= 1'b0;
      rdata          <= '0;
      busy           <= 1'b0;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_clken      <= 1'b0;
    end else begin
      state          <= state_n;
      addr_q         <= addr_n;
      we_q           <= we_n;
      wdata_q        <= wdata_n;
      cnt_q          <= cnt_n;
      ack            <= ack_n;
      rdata          <= rdata_n;
      busy           <= busy_n;
      avm_byteenable <= be_n;
      avm_chipselect <= cs_n;
      avm_write      <= write_n;
      avm_read       <= read_n;
      avm_clken      <= 1'b1;
    end
  end

  // Next state plus next values of the registered Moore outputs.
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    we_n    = we_q;
    wdata_n = wdata_q;
    cnt_n   = cnt_q;
    rdata_n = rdata;
    be_n    = avm_byteenable;
    ack_n   = 1'b0;
    cs_n    = 1'b0;
    write_n = 1'b0;
    read_n  = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          addr_n  = addr;
          we_n    = we;
          wdata_n = wdata;
          be_n    = lane_be_c;
          cs_n    = 1'b1;
          write_n = we;
          read_n  = !we;
          state_n = CMD;
        end
      end

      CMD: begin
        if (avm_waitrequest) begin
          cs_n    = 1'b1;
          write_n = we_q;
          read_n  = !we_q;
        end else if (we_q) begin
          ack_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n   = LAT_LOAD;
          state_n = RWAIT;
        end
      end

      RWAIT: begin
        if (cnt_q == '0) begin
          rdata_n = lane_byte_c;
          ack_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - LAT_CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_avm_byte_master.sv
// Directed bench for avm_byte_master: SRAM-like slave at latency 1, delay-line slave at latency 3.
module tb_avm_byte_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: READ_LATENCY=1 with SRAM model
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [12:0] addr_a = '0;
  logic [7:0]  wdata_a = '0;
  logic        ack_a, busy_a, cs_a, wr_a, rd_a, clken_a;
  logic [7:0]  rdata_a;
  logic [10:0] avm_addr_a;
  logic [3:0]  be_a;
  logic [31:0] wd_a;
  logic [31:0] rdin_a = 32'hDEADBEEF;
  logic        wait_a = 1'b0;

  // DUT B: READ_LATENCY=3 with delay-line slave
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [12:0] addr_b = '0;
  logic [7:0]  wdata_b = '0;
  logic        ack_b, busy_b, cs_b, wr_b, rd_b, clken_b;
  logic [7:0]  rdata_b;
  logic [10:0] avm_addr_b;
  logic [3:0]  be_b;
  logic [31:0] wd_b;
  logic [31:0] rdin_b;
  logic        wait_b = 1'b0;

  avm_byte_master #(.ADDR_W(13), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .avm_address(avm_addr_a),
    .avm_byteenable(be_a), .avm_chipselect(cs_a), .avm_write(wr_a), .avm_read(rd_a),
    .avm_writedata(wd_a), .avm_readdata(rdin_a), .avm_waitrequest(wait_a), .avm_clken(clken_a)
  );

  avm_byte_master #(.ADDR_W(13), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .avm_address(avm_addr_b),
    .avm_byteenable(be_b), .avm_chipselect(cs_b), .avm_write(wr_b), .avm_read(rd_b),
    .avm_writedata(wd_b), .avm_readdata(rdin_b), .avm_waitrequest(wait_b), .avm_clken(clken_b)
  );

  // SRAM slave model for DUT A
  logic [31:0] mem_a [2048];
  int acc_a = 0, acc_b = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (cs_a && !wait_a) begin
      acc_a <= acc_a + 1;
      if (wr_a) mem_a[avm_addr_a] <= merge(mem_a[avm_addr_a], wd_a, be_a);
    end
    if (cs_a && rd_a && !wait_a) rdin_a <= mem_a[avm_addr_a];
    else                         rdin_a <= 32'hDEADBEEF;
  end

  // Delay-line slave for DUT B: decoys on the cycles before the valid one
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  always @(posedge clk) begin
    v1 <= cs_b && rd_b && !wait_b;
    v2 <= v1;
    v3 <= v2;
    if (cs_b && !wait_b) acc_b <= acc_b + 1;
  end
  assign rdin_b = v3 ? 32'hC3B2A1F0 : (v2 ? 32'h5A5A5A5A : 32'hDEADBEEF);

  // Views of whichever DUT the current transaction targets
  logic sel = 1'b0;
  logic m_ack, m_busy, m_cs, m_wr, m_rd;
  logic [7:0] m_rdata;
  logic [10:0] m_addr;
  logic [3:0] m_be;
  logic [31:0] m_wd;
  assign m_ack   = sel ? ack_b : ack_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_cs    = sel ? cs_b : cs_a;
  assign m_wr    = sel ? wr_b : wr_a;
  assign m_rd    = sel ? rd_b : rd_a;
  assign m_rdata = sel ? rdata_b : rdata_a;
  assign m_addr  = sel ? avm_addr_b : avm_addr_a;
  assign m_be    = sel ? be_b : be_a;
  assign m_wd    = sel ? wd_b : wd_a;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request from req to ack, checking command outputs while in CMD.
  task automatic run_txn(input bit dut, input bit w, input logic [12:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input int exp_lat, input int stall,
                         input bit alter, input string tag);
    int cyc, acc0;
    bit got;
    logic [3:0] exp_be;
    exp_be = 4'b0001 << a[1:0];
    @(negedge clk);
    sel = dut;
    acc0 = dut ? acc_b : acc_a;
    if (dut) begin req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d; end
    else begin req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; wait_a = (stall > 0); end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc <= stall + 1) begin
        chk($sformatf("%s_c%0d_cs", tag, cyc), 32'(m_cs), 32'd1);
        chk($sformatf("%s_c%0d_write", tag, cyc), 32'(m_wr), 32'(w));
        chk($sformatf("%s_c%0d_read", tag, cyc), 32'(m_rd), 32'(!w));
        chk($sformatf("%s_c%0d_address", tag, cyc), 32'(m_addr), 32'(a[12:2]));
        chk($sformatf("%s_c%0d_be", tag, cyc), 32'(m_be), 32'(exp_be));
        chk($sformatf("%s_c%0d_busy", tag, cyc), 32'(m_busy), 32'd1);
        if (w) chk($sformatf("%s_c%0d_writedata", tag, cyc), m_wd, {4{d}});
      end
      if (alter && cyc == 1 && !dut) begin
        we_a = !w; addr_a = 13'h1FFF; wdata_a = 8'hEE;
      end
      if (!dut && stall > 0 && cyc == stall + 1) wait_a = 1'b0;
      if (m_ack) got = 1'b1;
    end
    chk($sformatf("%s_ack_latency", tag), got ? 32'(cyc) : 32'hFFFF, 32'(exp_lat));
    if (!w) chk($sformatf("%s_rdata", tag), 32'(m_rdata), 32'(exp_rd));
    if (dut) req_b = 1'b0; else req_a = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_ack_one_cycle", tag), 32'(m_ack), 32'd0);
    chk($sformatf("%s_busy_after", tag), 32'(m_busy), 32'd0);
    chk($sformatf("%s_accept_count", tag), 32'((dut ? acc_b : acc_a) - acc0), 32'd1);
    if (!w) chk($sformatf("%s_rdata_hold", tag), 32'(m_rdata), 32'(exp_rd));
  endtask

  typedef struct {
    logic        w;
    logic [12:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    for (int i = 0; i < 2048; i++) mem_a[i] = '0;

    vecs[0]  = '{1'b1, 13'h0006, 8'hA5, 8'h00, 2};
    vecs[1]  = '{1'b1, 13'h0100, 8'h11, 8'h00, 2};
    vecs[2]  = '{1'b1, 13'h0101, 8'h22, 8'h00, 2};
    vecs[3]  = '{1'b1, 13'h0102, 8'h33, 8'h00, 2};
    vecs[4]  = '{1'b1, 13'h0103, 8'h44, 8'h00, 2};
    vecs[5]  = '{1'b1, 13'h0001, 8'h5C, 8'h00, 2};
    vecs[6]  = '{1'b1, 13'h1FFF, 8'hFF, 8'h00, 2};
    vecs[7]  = '{1'b0, 13'h0102, 8'h00, 8'h33, 3};
    vecs[8]  = '{1'b0, 13'h0100, 8'h00, 8'h11, 3};
    vecs[9]  = '{1'b0, 13'h0103, 8'h00, 8'h44, 3};
    vecs[10] = '{1'b0, 13'h0006, 8'h00, 8'hA5, 3};
    vecs[11] = '{1'b0, 13'h0004, 8'h00, 8'h00, 3};
    vecs[12] = '{1'b0, 13'h0007, 8'h00, 8'h00, 3};
    vecs[13] = '{1'b0, 13'h1FFF, 8'h00, 8'hFF, 3};
    vecs[14] = '{1'b0, 13'h1FFC, 8'h00, 8'h00, 3};

    // Reset values
    #2;
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_rdata", 32'(rdata_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_address", 32'(avm_addr_a), 32'd0);
    chk("rst_be", 32'(be_a), 32'd0);
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_write", 32'(wr_a), 32'd0);
    chk("rst_read", 32'(rd_a), 32'd0);
    chk("rst_writedata", wd_a, 32'd0);
    chk("rst_clken_a", 32'(clken_a), 32'd0);
    chk("rst_clken_b", 32'(clken_b), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("clken_before_edge", 32'(clken_a), 32'd0);
    @(negedge clk);
    chk("clken_after_edge", 32'(clken_a), 32'd1);

    for (int i = 0; i < 15; i++)
      run_txn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].lat, 0, 1'b0,
              $sformatf("v%0d", i));

    // Waitrequest stalls
    run_txn(1'b0, 1'b0, 13'h0001, 8'h00, 8'h5C, 7, 4, 1'b0, "stall_rd");
    run_txn(1'b0, 1'b1, 13'h0005, 8'h7E, 8'h00, 4, 2, 1'b0, "stall_wr");
    run_txn(1'b0, 1'b0, 13'h0005, 8'h00, 8'h7E, 3, 0, 1'b0, "rd_after_stall_wr");
    run_txn(1'b0, 1'b0, 13'h0006, 8'h00, 8'hA5, 3, 0, 1'b0, "lane_untouched");

    // Inputs change while busy: original read completes, nothing else issued
    run_txn(1'b0, 1'b0, 13'h0100, 8'h00, 8'h11, 3, 0, 1'b1, "alter");
    run_txn(1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hFF, 3, 0, 1'b0, "alter_no_write");
    run_txn(1'b0, 1'b0, 13'h0103, 8'h00, 8'h44, 3, 0, 1'b0, "alter_orig_word");

    // READ_LATENCY=3 with decoys before the valid cycle
    run_txn(1'b1, 1'b0, 13'h0006, 8'h00, 8'hB2, 5, 0, 1'b0, "lat3_lane2");
    run_txn(1'b1, 1'b0, 13'h0003, 8'h00, 8'hC3, 5, 0, 1'b0, "lat3_lane3");

    // Reset asserted during RWAIT
    @(negedge clk);
    sel = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 13'h0101;
    @(negedge clk);
    chk("mid_cmd_cs", 32'(cs_a), 32'd1);
    @(negedge clk);
    chk("mid_rwait_cs", 32'(cs_a), 32'd0);
    chk("mid_rwait_busy", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(cs_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_ack", 32'(ack_a), 32'd0);
    chk("mid_rst_clken", 32'(clken_a), 32'd0);
    chk("mid_rst_rdata", 32'(rdata_a), 32'd0);
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_ack", 32'(ack_a), 32'd0);
    reset_n = 1'b1;
    #1 chk("mid_rel_clken0", 32'(clken_a), 32'd0);
    @(negedge clk);
    chk("mid_rel_clken1", 32'(clken_a), 32'd1);
    chk("mid_rel_no_ack", 32'(ack_a), 32'd0);
    run_txn(1'b0, 1'b0, 13'h0102, 8'h00, 8'h33, 3, 0, 1'b0, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
